// File: rtl/overture_pc_sequencer.sv
// ---------------------------------------------------------------------------
// overture_pc_sequencer
//
// Program-counter stage of the OVERTURE datapath. Once per instruction step it
// advances, branches, calls or returns an 8-bit program counter. The step is
// driven by the condition-unit output and the register-0 jump target. A small
// return-address stack backs call/ret. A halt instruction freezes the
// sequencer until reset.
//
// Parameters:
//   UUID        instance identifier (XORed into child UUIDs; no children here)
//   NAME        instance name string
//   STACK_DEPTH return-stack entries, 1..16
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active low
//   step       in   execute one instruction this cycle
//   cond[7:0]  in   condition-unit output, nonzero = true
//   is_jump    in   conditional jump
//   call       in   call to target
//   ret        in   return
//   halt_req   in   halt
//   target[7:0] in  jump/call destination
//   pc[7:0]    out  current program counter
//   taken      out  one-cycle pulse after a flow-changing step
//   halted     out  sequencer is in HALT (direct view of the state register)
//   stack_err  out  sticky stack overflow/underflow flag
//
// Handshake: there is no backpressure. Each cycle with step=1 in RUN
// consumes exactly one instruction. Results appear on the outputs the
// following cycle.
// ---------------------------------------------------------------------------
module overture_pc_sequencer #(
  parameter int          UUID        = 0,
  parameter string       NAME        = "",
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic [7:0] cond,
  input  logic       is_jump,
  input  logic       call,
  input  logic       ret,
  input  logic       halt_req,
  input  logic [7:0] target,
  output logic [7:0] pc,
  output logic       taken,
  output logic       halted,
  output logic       stack_err
);

  // The stack pointer counts occupied entries, 0..STACK_DEPTH.
  // Entry indices run 0..STACK_DEPTH-1.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        pc_q, pc_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic [7:0]        stack_q [STACK_DEPTH];
  logic [7:0]        stack_d [STACK_DEPTH];

  logic [7:0]        pc_inc;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;

  // The index values are only used when the pointer is in range.
  // That is, push_idx is used only when the stack is not full, and
  // pop_idx only when the stack is not empty. Truncating them is safe.
  assign pc_inc   = pc_q + 8'd1;
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
    err_d   = err_q;
    sp_d    = sp_q;
    stack_d = stack_q;

    if (state_q == S_RUN && step) begin
      if (halt_req) begin
        state_d = S_HALT;
      end else if (ret) begin
        if (sp_q != '0) begin
          pc_d    = stack_q[pop_idx];
          sp_d    = sp_q - SP_W'(1);
          taken_d = 1'b1;
        end else begin
          // Underflow: fall through to the next instruction.
          err_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (call) begin
        if (sp_q != SP_FULL) begin
          stack_d[push_idx] = pc_inc;
          sp_d              = sp_q + SP_W'(1);
          pc_d              = target;
          taken_d           = 1'b1;
        end else begin
          // Overflow: drop the call and fall through.
          err_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (is_jump && (|cond)) begin
        pc_d    = target;
        taken_d = 1'b1;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_RUN;
      pc_q    <= 8'd0;
      taken_q <= 1'b0;
      err_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents are not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign pc        = pc_q;
  assign taken     = taken_q;
  assign halted    = (state_q == S_HALT);
  assign stack_err = err_q;

endmodule

// File: tb/tb_overture_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_overture_pc_sequencer
//
// Directed bench for overture_pc_sequencer. The first part is a table of
// {inputs, expected outputs} records applied one per clock. It is followed
// by hand-written sequences for stack overflow/underflow and for
// halt/reset. Return addresses in the stack sequence are tracked in a small
// expected queue.
// ---------------------------------------------------------------------------
module tb_overture_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic [7:0] cond;
  logic       is_jump;
  logic       call;
  logic       ret;
  logic       halt_req;
  logic [7:0] target;
  logic [7:0] pc;
  logic       taken;
  logic       halted;
  logic       stack_err;

  always #5 clk = ~clk;

  overture_pc_sequencer #(
    .UUID        (0),
    .NAME        ("pcseq"),
    .STACK_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step      (step),
    .cond      (cond),
    .is_jump   (is_jump),
    .call      (call),
    .ret       (ret),
    .halt_req  (halt_req),
    .target    (target),
    .pc        (pc),
    .taken     (taken),
    .halted    (halted),
    .stack_err (stack_err)
  );

  // ---------------- scoreboard state ----------------
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [7:0]  exp_q[$];

  typedef struct {
    logic       rst;
    logic       step;
    logic [7:0] cond;
    logic       jmp;
    logic       cl;
    logic       rt;
    logic       hl;
    logic [7:0] tgt;
    logic [7:0] e_pc;
    logic       e_tk;
    logic       e_hd;
    logic       e_er;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic s, input logic [7:0] c,
                       input logic j, input logic cl, input logic rt,
                       input logic hl, input logic [7:0] t);
    @(negedge clk);
    rst = r; step = s; cond = c; is_jump = j;
    call = cl; ret = rt; halt_req = hl; target = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string nm, input logic [7:0] act,
                           input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_pc,
                           input logic e_tk, input logic e_hd,
                           input logic e_er);
    check_val({tag, ".pc"},        pc,               e_pc);
    check_val({tag, ".taken"},     {7'd0, taken},    {7'd0, e_tk});
    check_val({tag, ".halted"},    {7'd0, halted},   {7'd0, e_hd});
    check_val({tag, ".stack_err"}, {7'd0, stack_err}, {7'd0, e_er});
  endtask

  function automatic vec_t mk(logic r, logic s, logic [7:0] c, logic j,
                              logic cl, logic rt, logic hl, logic [7:0] t,
                              logic [7:0] epc, logic etk, logic ehd,
                              logic eer);
    vec_t v;
    v.rst = r; v.step = s; v.cond = c; v.jmp = j; v.cl = cl; v.rt = rt;
    v.hl = hl; v.tgt = t; v.e_pc = epc; v.e_tk = etk; v.e_hd = ehd;
    v.e_er = eer;
    return v;
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [7:0] exp_pc;
    logic [7:0] ret_addr;
    logic [7:0] tgt;

    rst = 1'b1; step = 1'b0; cond = 8'd0; is_jump = 1'b0;
    call = 1'b0; ret = 1'b0; halt_req = 1'b0; target = 8'd0;

    //                 rst step cond  jmp cl rt hl tgt    pc    tk hd er
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h55, 8'h00, 0, 0, 0)); // reset beats call
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h02, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h01, 1, 0, 0, 0, 8'h0A, 8'h0A, 1, 0, 0)); // jump to 10
    vecs.push_back(mk(1, 1, 8'h00, 1, 0, 0, 0, 8'h40, 8'h0B, 0, 0, 0)); // cond=0
    vecs.push_back(mk(1, 1, 8'h80, 1, 0, 0, 0, 8'h40, 8'h40, 1, 0, 0)); // cond msb
    vecs.push_back(mk(1, 0, 8'h01, 1, 0, 0, 0, 8'h99, 8'h40, 0, 0, 0)); // idle holds
    vecs.push_back(mk(1, 1, 8'h02, 1, 0, 0, 0, 8'h05, 8'h05, 1, 0, 0)); // pc=5
    vecs.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 8'h20, 8'h20, 1, 0, 0)); // call, push 6
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h21, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h22, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 8'h00, 8'h06, 1, 0, 0)); // ret -> 6
    vecs.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 8'h30, 8'h30, 1, 0, 0)); // call, push 7
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 8'h00, 8'h07, 1, 0, 0)); // ret right after
    vecs.push_back(mk(1, 1, 8'h10, 1, 0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0)); // 255+1 wraps
    vecs.push_back(mk(1, 1, 8'h04, 1, 0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h00, 0, 1, 0, 0, 8'h50, 8'h50, 1, 0, 0)); // call at 255 pushes 0
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0)); // ret -> 0
    vecs.push_back(mk(1, 1, 8'h01, 1, 1, 0, 0, 8'h60, 8'h60, 1, 0, 0)); // call beats jump
    vecs.push_back(mk(1, 1, 8'h00, 0, 1, 1, 0, 8'h70, 8'h01, 1, 0, 0)); // ret beats call
    vecs.push_back(mk(1, 1, 8'h01, 1, 0, 1, 0, 8'h70, 8'h02, 0, 0, 1)); // underflow
    vecs.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 8'h03, 0, 0, 1)); // err sticky
    vecs.push_back(mk(0, 1, 8'h00, 0, 1, 0, 0, 8'h77, 8'h00, 0, 0, 0)); // reset clears

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].step, vecs[i].cond, vecs[i].jmp,
            vecs[i].cl, vecs[i].rt, vecs[i].hl, vecs[i].tgt);
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_tk,
                vecs[i].e_hd, vecs[i].e_er);
    end

    // ---- stack fill, overflow, unwind, underflow (pc starts at 0) ----
    exp_pc = 8'h00;
    exp_q.delete();
    for (int k = 1; k <= 4; k++) begin
      tgt = 8'(k * 16);
      drive(1, 1, 8'h00, 0, 1, 0, 0, tgt);
      exp_q.push_back(exp_pc + 8'd1);
      exp_pc = tgt;
      check_all($sformatf("fill%0d", k), exp_pc, 1'b1, 1'b0, 1'b0);
    end
    drive(1, 1, 8'h00, 0, 1, 0, 0, 8'h50);               // 5th call overflows
    exp_pc = exp_pc + 8'd1;
    check_all("overflow", exp_pc, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 8'h00, 0, 0, 1, 0, 8'h00);
      ret_addr = exp_q.pop_back();
      exp_pc = ret_addr;
      check_all($sformatf("unwind%0d", k), exp_pc, 1'b1, 1'b0, 1'b1);
    end
    drive(1, 1, 8'h00, 0, 0, 1, 0, 8'h00);               // 5th ret underflows
    exp_pc = exp_pc + 8'd1;
    check_all("underflow", exp_pc, 1'b0, 1'b0, 1'b1);

    // ---- halt with competing decodes, then reset out of HALT ----
    drive(0, 0, 8'h00, 0, 0, 0, 0, 8'h00);
    check_all("h_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1, 1, 8'h00, 0, 0, 1, 0, 8'h00);               // underflow sets err
    check_all("h_err", 8'h01, 1'b0, 1'b0, 1'b1);
    drive(1, 1, 8'h00, 0, 1, 0, 0, 8'h20);               // push 2
    check_all("h_call", 8'h20, 1'b1, 1'b0, 1'b1);
    drive(1, 1, 8'hFF, 1, 1, 0, 1, 8'h88);               // halt wins
    check_all("h_halt", 8'h20, 1'b0, 1'b1, 1'b1);
    drive(1, 1, 8'h00, 0, 0, 1, 0, 8'h00);
    check_all("h_ret_ign", 8'h20, 1'b0, 1'b1, 1'b1);
    drive(1, 1, 8'h00, 0, 1, 0, 0, 8'h33);
    check_all("h_call_ign", 8'h20, 1'b0, 1'b1, 1'b1);
    drive(1, 1, 8'h01, 1, 0, 0, 0, 8'h44);
    check_all("h_jump_ign", 8'h20, 1'b0, 1'b1, 1'b1);
    drive(0, 1, 8'h01, 1, 0, 0, 1, 8'h44);               // reset beats halt
    check_all("h_exit", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1, 1, 8'h00, 0, 0, 0, 0, 8'h00);
    check_all("h_run", 8'h01, 1'b0, 1'b0, 1'b0);
    drive(1, 1, 8'h00, 0, 0, 1, 0, 8'h00);               // sp was cleared
    check_all("h_sp_clr", 8'h02, 1'b0, 1'b0, 1'b1);

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
